// File: rtl/sram_pkg.sv
// Shared types and constants for the 1RW/1R SRAM and its clear engine.
`timescale 1ns/1ps
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clrState_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_WMASKS = 4;
    localparam int unsigned DEFAULT_LANE_WIDTH = DEFAULT_DATA_WIDTH / DEFAULT_NUM_WMASKS;

    function automatic int unsigned laneWidth(input int unsigned dataWidth,
                                              input int unsigned numLanes);
        return dataWidth / numLanes;
    endfunction

endpackage

// File: rtl/sram_clear_engine.sv
// Clear sequencer: walks every address once after reset or on request,
// then holds in IDLE and reports the array as usable.
`timescale 1ns/1ps
module sram_clear_engine
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clearReq_i,
    output logic                  clrWe_o,
    output logic [ADDR_WIDTH-1:0] clrAddr_o,
    output logic                  initDone_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clrState_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clrAddr_q, clrAddr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    // The counter parks on the last address in IDLE and is rewound on a new request.
    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        clrWe_o   = 1'b0;
        case (state_q)
            CLEAR: begin
                clrWe_o = 1'b1;
                if (clrAddr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clrAddr_d = clrAddr_q + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                if (clearReq_i) begin
                    state_d   = CLEAR;
                    clrAddr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // A request drops readiness in its own cycle so no port access races the clear.
    assign initDone_o = (state_q == IDLE) && !clearReq_i;
    assign clrAddr_o  = clrAddr_q;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parameterised 1RW + 1R SRAM with lane write masks, optional output
// register, port-0 to port-1 write bypass and a built-in clear engine.
`timescale 1ns/1ps
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           NUM_WMASKS  = DEFAULT_NUM_WMASKS,
    parameter int unsigned           OUT_REG     = 0,
    parameter int unsigned           BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk0,
    input  logic                  rstb,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_vld,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_vld,
    input  logic                  clear_req,
    output logic                  init_done
);

    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned LANE_WIDTH = laneWidth(DATA_WIDTH, NUM_WMASKS);

    if ((DATA_WIDTH % NUM_WMASKS) != 0) begin : gMaskCheck
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of NUM_WMASKS");
    end

    logic                  clrWe;
    logic [ADDR_WIDTH-1:0] clrAddr;
    logic                  initDone;
    logic                  wr0, rd0, rd1;
    logic [DATA_WIDTH-1:0] rd1Word;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData0_q, rdData1_q;
    logic                  rdVld0_q, rdVld1_q;

    sram_clear_engine #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uClearEngine (
        .clk_i      (clk0),
        .rst_ni     (rstb),
        .clearReq_i (clear_req),
        .clrWe_o    (clrWe),
        .clrAddr_o  (clrAddr),
        .initDone_o (initDone)
    );

    assign init_done = initDone;
    assign wr0       = initDone & ~csb0 & ~web0;
    assign rd0       = initDone & ~csb0 & web0;
    assign rd1       = initDone & ~csb1;

    // Array has no reset; the clear engine is the only thing that defines it.
    always_ff @(posedge clk0) begin
        if (clrWe) begin
            mem[clrAddr] <= CLEAR_VALUE;
        end else if (wr0) begin
            for (int l = 0; l < NUM_WMASKS; l++) begin
                if (wmask0[l]) begin
                    mem[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd1Word = mem[addr1];
        if ((BYPASS != 0) && wr0 && (addr0 == addr1)) begin
            for (int l = 0; l < NUM_WMASKS; l++) begin
                if (wmask0[l]) begin
                    rd1Word[l*LANE_WIDTH +: LANE_WIDTH] = din0[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rstb) begin
        if (!rstb) begin
            rdData0_q <= '0;
            rdData1_q <= '0;
            rdVld0_q  <= 1'b0;
            rdVld1_q  <= 1'b0;
        end else begin
            rdVld0_q <= rd0;
            rdVld1_q <= rd1;
            if (rd0) begin
                rdData0_q <= mem[addr0];
            end
            if (rd1) begin
                rdData1_q <= rd1Word;
            end
        end
    end

    if (OUT_REG != 0) begin : gOutReg
        logic [DATA_WIDTH-1:0] dout0Out_q, dout1Out_q;
        logic                  vld0Out_q, vld1Out_q;

        // A read still in flight when a clear starts is dropped rather than flagged valid.
        always_ff @(posedge clk0 or negedge rstb) begin
            if (!rstb) begin
                dout0Out_q <= '0;
                dout1Out_q <= '0;
                vld0Out_q  <= 1'b0;
                vld1Out_q  <= 1'b0;
            end else begin
                vld0Out_q <= rdVld0_q & initDone;
                vld1Out_q <= rdVld1_q & initDone;
                if (rdVld0_q && initDone) begin
                    dout0Out_q <= rdData0_q;
                end
                if (rdVld1_q && initDone) begin
                    dout1Out_q <= rdData1_q;
                end
            end
        end

        assign dout0     = dout0Out_q;
        assign dout1     = dout1Out_q;
        assign dout0_vld = vld0Out_q;
        assign dout1_vld = vld1Out_q;
    end else begin : gNoOutReg
        assign dout0     = rdData0_q;
        assign dout1     = rdData1_q;
        assign dout0_vld = rdVld0_q;
        assign dout1_vld = rdVld1_q;
    end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: default build, an OUT_REG=1/BYPASS=0 build on the
// same inputs, and a 64x16 build with byte lanes.
`timescale 1ns/1ps
module tb_sram_1rw1r_param;

    localparam int DEPTH = 256;
    localparam int HMAX  = 4096;
    localparam int NVEC  = 12;

    logic        clk = 1'b0;
    logic        rstb;
    logic        csb0, web0, csb1, clearReq;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] doutA0, doutA1, doutB0, doutB1;
    logic        vldA0, vldA1, vldB0, vldB1, initA, initB;

    logic        csbC0, webC0, csbC1, clearReqC;
    logic [7:0]  wmaskC;
    logic [3:0]  addrC0, addrC1;
    logic [63:0] dinC, doutC0, doutC1;
    logic        vldC0, vldC1, initC;

    always #5 clk = ~clk;

    sram_1rw1r_param dutA (
        .clk0(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(doutA0), .dout0_vld(vldA0),
        .csb1(csb1), .addr1(addr1), .dout1(doutA1), .dout1_vld(vldA1),
        .clear_req(clearReq), .init_done(initA)
    );

    sram_1rw1r_param #(.OUT_REG(1), .BYPASS(0)) dutB (
        .clk0(clk), .rstb(rstb), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(doutB0), .dout0_vld(vldB0),
        .csb1(csb1), .addr1(addr1), .dout1(doutB1), .dout1_vld(vldB1),
        .clear_req(clearReq), .init_done(initB)
    );

    sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_WMASKS(8)) dutC (
        .clk0(clk), .rstb(rstb), .csb0(csbC0), .web0(webC0), .wmask0(wmaskC),
        .addr0(addrC0), .din0(dinC), .dout0(doutC0), .dout0_vld(vldC0),
        .csb1(csbC1), .addr1(addrC1), .dout1(doutC1), .dout1_vld(vldC1),
        .clear_req(clearReqC), .init_done(initC)
    );

    typedef struct {
        logic        csb0;
        logic        web0;
        logic [3:0]  mask;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        csb1;
        logic [7:0]  a1;
        logic [31:0] e0;
        logic        ev0;
        logic [31:0] e1;
        logic        ev1;
        logic        chkB;
        logic [31:0] eB0;
        logic [31:0] eB1;
    } vec_t;

    vec_t        vecs [NVEC];
    int          testsRun = 0;
    int          testsFailed = 0;

    // Reference model: plain word array plus a per-edge log of issued reads.
    logic [31:0] modelMem [DEPTH];
    bit          modelDone;
    int          clrCnt;
    int          cyc;
    int          lastReset;
    bit          h0v [HMAX];
    logic [31:0] h0d [HMAX];
    bit          h1v [HMAX];
    logic [31:0] h1New [HMAX];
    logic [31:0] h1Old [HMAX];

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = oldW;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) r[8*l +: 8] = newW[8*l +: 8];
        end
        return r;
    endfunction

    function automatic bit expVld(input int port, input int extra);
        int idx;
        idx = cyc - extra;
        if (idx <= lastReset) return 1'b0;
        return (port == 0) ? h0v[idx] : h1v[idx];
    endfunction

    function automatic logic [31:0] expData(input int port, input bit bypass, input int extra);
        for (int k = cyc - extra; k > lastReset; k--) begin
            if (port == 0 && h0v[k]) return h0d[k];
            if (port == 1 && h1v[k]) return bypass ? h1New[k] : h1Old[k];
        end
        return 32'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic c0, input logic w0, input logic [3:0] m,
                                 input logic [7:0] a0, input logic [31:0] d0,
                                 input logic c1, input logic [7:0] a1, input logic cr);
        csb0     = c0;
        web0     = w0;
        wmask0   = m;
        addr0    = a0;
        din0     = d0;
        csb1     = c1;
        addr1    = a1;
        clearReq = cr;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic checkAll();
        checkOutput("A init_done", 64'(initA), 64'(modelDone && !clearReq));
        checkOutput("B init_done", 64'(initB), 64'(modelDone && !clearReq));
        checkOutput("A dout0", 64'(doutA0), 64'(expData(0, 1'b1, 0)));
        checkOutput("A vld0", 64'(vldA0), 64'(expVld(0, 0)));
        checkOutput("A dout1", 64'(doutA1), 64'(expData(1, 1'b1, 0)));
        checkOutput("A vld1", 64'(vldA1), 64'(expVld(1, 0)));
        checkOutput("B dout0", 64'(doutB0), 64'(expData(0, 1'b0, 1)));
        checkOutput("B vld0", 64'(vldB0), 64'(expVld(0, 1)));
        checkOutput("B dout1", 64'(doutB1), 64'(expData(1, 1'b0, 1)));
        checkOutput("B vld1", 64'(vldB1), 64'(expVld(1, 1)));
    endtask

    // Resolve the model against the inputs seen at the coming edge, then compare after it.
    task automatic step();
        bit          ok, r0, w0, r1, cr;
        logic [7:0]  wA;
        logic [3:0]  wM;
        logic [31:0] wD, d0, dOld, dNew;
        if (cyc >= HMAX - 2) begin
            $display("[TB] FAIL cycleBudget: got %0d cycles, limit %0d", cyc, HMAX - 2);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        cr   = clearReq;
        ok   = modelDone && !cr;
        r0   = ok && !csb0 && web0;
        w0   = ok && !csb0 && !web0;
        r1   = ok && !csb1;
        wA   = addr0;
        wM   = wmask0;
        wD   = din0;
        d0   = modelMem[addr0];
        dOld = modelMem[addr1];
        dNew = (w0 && addr0 == addr1) ? mergeLanes(dOld, din0, wmask0) : dOld;
        @(posedge clk);
        #1;
        cyc++;
        h0v[cyc]   = r0;
        h0d[cyc]   = d0;
        h1v[cyc]   = r1;
        h1New[cyc] = dNew;
        h1Old[cyc] = dOld;
        if (w0) modelMem[wA] = mergeLanes(modelMem[wA], wD, wM);
        if (!modelDone) begin
            modelMem[clrCnt] = 32'h0;
            clrCnt++;
            if (clrCnt == DEPTH) modelDone = 1'b1;
        end else if (cr) begin
            modelDone = 1'b0;
            clrCnt    = 0;
        end
        checkAll();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " A dout0"}, 64'(doutA0), 64'h0);
        checkOutput({tag, " A dout1"}, 64'(doutA1), 64'h0);
        checkOutput({tag, " A vld0"}, 64'(vldA0), 64'h0);
        checkOutput({tag, " A vld1"}, 64'(vldA1), 64'h0);
        checkOutput({tag, " A init"}, 64'(initA), 64'h0);
        checkOutput({tag, " B dout0"}, 64'(doutB0), 64'h0);
        checkOutput({tag, " B dout1"}, 64'(doutB1), 64'h0);
        checkOutput({tag, " B vld1"}, 64'(vldB1), 64'h0);
        checkOutput({tag, " C dout0"}, doutC0, 64'h0);
        checkOutput({tag, " C init"}, 64'(initC), 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int cInit;

        // Directed vectors, applied after the first clear; expectations for the default build.
        vecs[0]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'hFF, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 4'h5, 8'h10, 32'h11223344, 1'b1, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 32'hDE22BE44, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h00, 32'hDE22BE44, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDE22BE44, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 4'hF, 8'h20, 32'hA5A5A5A5, 1'b0, 8'h20, 32'hDE22BE44, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h20, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hDE22BE44, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'h3, 8'h30, 32'hFFFFFFFF, 1'b0, 8'h30, 32'h0,        1'b0, 32'h0000FFFF, 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5};
        vecs[9]  = '{1'b0, 1'b0, 4'hF, 8'h05, 32'h12345678, 1'b0, 8'h10, 32'h0,        1'b0, 32'hDE22BE44, 1'b1, 1'b1, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 4'h0, 8'h05, 32'h0,        1'b0, 8'h30, 32'h12345678, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h00, 32'h12345678, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 32'h0, 32'h0};

        cyc       = 0;
        lastReset = 0;
        modelDone = 1'b0;
        clrCnt    = 0;
        rstb      = 1'b1;
        idle();
        csbC0 = 1'b1; webC0 = 1'b1; wmaskC = 8'h00; addrC0 = 4'h0; dinC = 64'h0;
        csbC1 = 1'b1; addrC1 = 4'h0; clearReqC = 1'b0;

        #2 rstb = 1'b0;
        #1 checkResetOutputs("reset");
        #19 rstb = 1'b1;

        n = 0;
        cInit = -1;
        while (!initA && n < 400) begin
            step();
            n++;
            if (initC && cInit < 0) cInit = n;
        end
        checkOutput("init latency A", 64'(n), 64'd256);
        checkOutput("init latency C", 64'(cInit), 64'd16);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].csb0, vecs[i].web0, vecs[i].mask, vecs[i].a0, vecs[i].d0,
                          vecs[i].csb1, vecs[i].a1, 1'b0);
            step();
            checkOutput($sformatf("vec%0d A dout0", i), 64'(doutA0), 64'(vecs[i].e0));
            checkOutput($sformatf("vec%0d A vld0", i), 64'(vldA0), 64'(vecs[i].ev0));
            checkOutput($sformatf("vec%0d A dout1", i), 64'(doutA1), 64'(vecs[i].e1));
            checkOutput($sformatf("vec%0d A vld1", i), 64'(vldA1), 64'(vecs[i].ev1));
            if (vecs[i].chkB) begin
                checkOutput($sformatf("vec%0d B dout0", i), 64'(doutB0), 64'(vecs[i].eB0));
                checkOutput($sformatf("vec%0d B dout1", i), 64'(doutB1), 64'(vecs[i].eB1));
            end
        end

        // Wide build: a lane-7-only write must touch bits 63:56 and nothing else.
        idle();
        csbC0 = 1'b0; webC0 = 1'b0; wmaskC = 8'hFF; addrC0 = 4'h3; dinC = 64'h0123456789ABCDEF;
        step();
        wmaskC = 8'h80; dinC = 64'hFFFFFFFFFFFFFFFF;
        step();
        webC0 = 1'b1; csbC1 = 1'b0; addrC1 = 4'h3;
        step();
        checkOutput("C lane7 dout0", doutC0, 64'hFF23456789ABCDEF);
        checkOutput("C lane7 vld0", 64'(vldC0), 64'h1);
        checkOutput("C lane7 dout1", doutC1, 64'hFF23456789ABCDEF);
        csbC0 = 1'b1; addrC1 = 4'h4;
        step();
        checkOutput("C cleared addr4", doutC1, 64'h0);
        checkOutput("C vld1 addr4", 64'(vldC1), 64'h1);
        csbC1 = 1'b1;

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 4'($urandom),
                          8'(8'h40 + $urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 2) == 0, 8'(8'h40 + $urandom_range(0, 7)), 1'b0);
            step();
        end

        idle();
        step();
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
        step();
        n = 0;
        while (!initA && n < 400) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 8'h05, 1'b0);
            step();
            n++;
        end
        checkOutput("clear_req latency", 64'(n), 64'd256);
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 8'h05, 1'b0);
        step();
        checkOutput("after clear dout0", 64'(doutA0), 64'h0);
        checkOutput("after clear vld0", 64'(vldA0), 64'h1);
        checkOutput("after clear dout1", 64'(doutA1), 64'h0);

        // Leave non-zero data on the outputs, then reset halfway through a clear.
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'hCAFEF00D, 1'b1, 8'h00, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h10, 1'b0);
        step();
        idle();
        step();
        checkOutput("pre-reset B dout1", 64'(doutB1), 64'hCAFEF00D);
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b1);
        step();
        idle();
        for (int i = 0; i < 128; i++) step();
        #2 rstb = 1'b0;
        #1 checkResetOutputs("mid-clear reset");
        lastReset = cyc;
        modelDone = 1'b0;
        clrCnt    = 0;
        #4 rstb = 1'b1;
        n = 0;
        while (!initA && n < 400) begin
            step();
            n++;
        end
        checkOutput("post-reset latency", 64'(n), 64'd256);
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10, 1'b0);
        step();
        checkOutput("post-reset read", 64'(doutA1), 64'h0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, write-mask lanes; DATA_WIDTH divisible by NUM_WMASKS (elaboration error otherwise).
REQ-004 SHALL have parameter OUT_REG, default 0, adding one output register stage to both read ports when 1.
REQ-005 SHALL have parameter BYPASS, default 1: port-1 read colliding with a port-0 write returns new data when 1, old data when 0.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit value written by the clear engine.
REQ-007 SHALL have ports: clk0 in 1, the single clock, all logic on posedge; rstb in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: csb0 in 1, active-low select; web0 in 1, active-low write; wmask0 in NUM_WMASKS, lane enables; addr0 in ADDR_WIDTH; din0 in DATA_WIDTH; dout0 out DATA_WIDTH; dout0_vld out 1.
REQ-009 SHALL have ports: csb1 in 1, active-low read select; addr1 in ADDR_WIDTH; dout1 out DATA_WIDTH; dout1_vld out 1.
REQ-010 SHALL have ports: clear_req in 1, pulse starting a full clear; init_done out 1, high when the array is usable.

Function
REQ-011 SHALL implement FSM states CLEAR and IDLE; exit from reset is to CLEAR.
REQ-012 In CLEAR, SHALL write CLEAR_VALUE (all lanes) to address 0, 1, ... depth-1, one word per cycle, then enter IDLE; init_done rises in the cycle after the last write.
REQ-013 In IDLE, clear_req=1 SHALL drop init_done and enter CLEAR from address 0 on the next edge; clear_req during CLEAR SHALL be ignored.
REQ-014 While init_done=0, csb0/csb1 SHALL be ignored, and dout0_vld/dout1_vld SHALL stay 0.
REQ-015 Port-0 write (csb0=0, web0=0): each lane i with wmask0[i]=1 SHALL be updated at that edge; other lanes SHALL be preserved; dout0 holds; dout0_vld=0.
REQ-016 Port-0 read (csb0=0, web0=1) at edge N SHALL present mem[addr0] on dout0 with dout0_vld=1 after edge N+1+OUT_REG.
REQ-017 Port-1 read (csb1=0) at edge N SHALL present data on dout1 with dout1_vld=1 after edge N+1+OUT_REG.
REQ-018 Same-edge port-0 write and port-1 read to equal addresses: BYPASS=1 SHALL return the lane-merged new word; BYPASS=0 the pre-write word.
REQ-019 dout0/dout1 SHALL hold their last value when no read is issued; the vld flags are single-cycle pulses per read.
REQ-020 Address wrap SHALL not occur; clear-engine counter SHALL stop at depth-1.

Reset
REQ-021 rstb=0 SHALL asynchronously force: state CLEAR, clear address 0, init_done 0, dout0/dout1 0, dout0_vld/dout1_vld 0, output pipeline registers 0.
REQ-022 The memory array SHALL not be reset directly; contents are defined only after the clear completes.
REQ-023 Reset asserted mid-clear or mid-read SHALL abort the operation; the clear restarts from address 0 after release.

Structure
REQ-024 Shared package sram_pkg SHALL hold the FSM state enum (CLEAR, IDLE) and the lane-merge width constants.
REQ-025 The clear FSM and address counter SHALL form sub-module sram_clear_engine; the array, muxing and output pipeline stay in the top level.

Verification
REQ-026 Reset release, defaults: init_done rises exactly 256 cycles later; port-1 reads of addresses 0x00 and 0xFF return 0x00000000.
REQ-027 Write 0xDEADBEEF to 0x10 with mask 4'b1111, then mask 4'b0101 with 0x11223344 -> read returns 0xDE22BE44 one cycle after issue (OUT_REG=0), two cycles after (OUT_REG=1).
REQ-028 Same-edge write 0xA5A5A5A5 to 0x20 (old 0x0) and port-1 read of 0x20 -> dout1=0xA5A5A5A5 with BYPASS=1, 0x00000000 with BYPASS=0.
REQ-029 clear_req after writing 0x12345678 to 0x05 -> init_done low for 256 cycles, reads ignored (vld=0), then 0x05 reads 0x00000000.
REQ-030 rstb pulsed low at clear address 0x80 -> all outputs 0 immediately; the clear restarts at 0 and init_done rises 256 cycles after release.
REQ-031 Non-default build DATA_WIDTH=64, ADDR_WIDTH=4, NUM_WMASKS=8 -> clear takes 16 cycles; byte-lane write of lane 7 alone changes only bits 63:56.
